mux_nx1_stream: RTL and testbench

//  Parametrised N-channel to 1 stream multiplexer with valid/ready handshake and a registered output stage.

---
 rtl/mux_pkg.sv | 25 ++
 rtl/rr_arbiter_nbit.sv | 43 ++++
 rtl/mux_nx1_stream.sv | 184 ++++++++++++++++++
 tb/tb_mux_nx1_stream.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the N:1 stream multiplexer slice.
//   clog2      : constant-safe ceiling log2, used to size channel indices
//   ST_*       : packet-lock FSM state encodings
//   MODE_*     : RR_MODE encodings (sel-driven vs round-robin)
package mux_pkg;

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_LOCKED = 1'b1;

    localparam int unsigned MODE_SEL = 0;
    localparam int unsigned MODE_RR  = 1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter_nbit.sv
// Combinational round-robin arbiter.
// Picks the first asserted request scanning ptr+1, ptr+2, ... modulo N_CH.
//   req     : per-channel request vector
//   ptr     : index of the most recently granted channel (must be < N_CH)
//   gnt_idx : granted channel index (meaningful only when gnt_any=1)
//   gnt_any : at least one request is asserted
module rr_arbiter_nbit
    import mux_pkg::*;
#(
    parameter int unsigned N_CH = 4,
    localparam int unsigned SEL_W = clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_any
);

    logic [2*N_CH-1:0] dbl;
    logic [N_CH-1:0]   rot;
    int                off;
    int                idx;

    always_comb begin
        // Rotate so that bit 0 of rot is channel ptr+1; the doubled vector handles the wrap.
        dbl     = {req, req} >> (32'(ptr) + 32'd1);
        rot     = dbl[N_CH-1:0];
        gnt_any = |rot;
        off     = 0;
        // Descending scan so the lowest set offset wins.
        for (int j = N_CH - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off = j;
            end
        end
        idx = int'(ptr) + 1 + off;
        if (idx >= int'(N_CH)) begin
            idx = idx - int'(N_CH);
        end
        gnt_idx = SEL_W'(idx);
    end

endmodule

// File: rtl/mux_nx1_stream.sv
// N-channel to 1 stream multiplexer with valid/ready handshake and registered output.
// Channel is chosen by sel (RR_MODE=0) or round-robin among valid channels (RR_MODE=1).
// Optional packet lock: define MUX_NX1_STREAM_PKT_LOCK_EN to keep the grant on one channel
// from its first beat with in_last=0 until the beat carrying in_last=1.
// Ports:
//   clk, reset_n        : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   : per-channel handshake
//   in_data             : flattened data, channel k = in_data[k*W +: W]
//   in_last             : per-channel end-of-packet flag
//   sel                 : channel select (RR_MODE=0 only)
//   out_valid/out_ready : output handshake
//   out_data/out_last   : registered beat and its end-of-packet flag
//   out_ch              : source channel of the registered beat
module mux_nx1_stream
    import mux_pkg::*;
#(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned W       = 4,
    parameter int unsigned RR_MODE = MODE_SEL,
    localparam int unsigned SEL_W  = clog2(N_CH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_CH-1:0]   in_valid,
    input  logic [N_CH*W-1:0] in_data,
    input  logic [N_CH-1:0]   in_last,
    output logic [N_CH-1:0]   in_ready,
    input  logic [SEL_W-1:0]  sel,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic              out_last,
    output logic [SEL_W-1:0]  out_ch,
    input  logic              out_ready
);

    logic [SEL_W-1:0] base_idx;
    logic             base_any;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_any;
    logic             can_load;
    logic             xfer;
    logic [W-1:0]     sel_data;
    logic             sel_last;

    logic             out_valid_d, out_valid_q;
    logic [W-1:0]     out_data_d,  out_data_q;
    logic             out_last_d,  out_last_q;
    logic [SEL_W-1:0] out_ch_d,    out_ch_q;

    // Base grant: arbiter in round-robin mode, sel port otherwise.
    if (RR_MODE == MODE_RR) begin : gen_rr
        logic [SEL_W-1:0] rr_ptr_d, rr_ptr_q;

        rr_arbiter_nbit #(
            .N_CH(N_CH)
        ) u_arb (
            .req    (in_valid),
            .ptr    (rr_ptr_q),
            .gnt_idx(base_idx),
            .gnt_any(base_any)
        );

        always_comb begin
            rr_ptr_d = rr_ptr_q;
            if (xfer) begin
                rr_ptr_d = grant_idx;
            end
        end

        // Reset to the last channel so the first scan starts at channel 0.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                rr_ptr_q <= SEL_W'(N_CH - 1);
            end else begin
                rr_ptr_q <= rr_ptr_d;
            end
        end
    end else begin : gen_sel
        assign base_idx = sel;
        assign base_any = ({1'b0, sel} < (SEL_W + 1)'(N_CH));
    end

`ifdef MUX_NX1_STREAM_PKT_LOCK_EN
    logic             lock_state_d, lock_state_q;
    logic [SEL_W-1:0] lock_ch_d,    lock_ch_q;
`endif

    always_comb begin
        grant_idx = base_idx;
        grant_any = base_any;
`ifdef MUX_NX1_STREAM_PKT_LOCK_EN
        if (lock_state_q == ST_LOCKED) begin
            grant_idx = lock_ch_q;
            grant_any = 1'b1;
        end
`endif
    end

    assign can_load = !out_valid_q || out_ready;

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int k = 0; k < int'(N_CH); k++) begin
            if (grant_idx == SEL_W'(k)) begin
                sel_data = in_data[k*W +: W];
                sel_last = in_last[k];
            end
        end
    end

    // in_ready is forced low while reset is asserted so no producer sees a handshake.
    always_comb begin
        in_ready = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            in_ready[k] = reset_n && can_load && grant_any && (grant_idx == SEL_W'(k));
        end
    end

    assign xfer = |(in_valid & in_ready);

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_ch_d    = out_ch_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_last_d  = sel_last;
            out_ch_d    = grant_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_ch_q    <= out_ch_d;
        end
    end

`ifdef MUX_NX1_STREAM_PKT_LOCK_EN
    always_comb begin
        lock_state_d = lock_state_q;
        lock_ch_d    = lock_ch_q;
        if (xfer) begin
            if (lock_state_q == ST_IDLE) begin
                // A single-beat packet (in_last=1) never locks.
                if (!sel_last) begin
                    lock_state_d = ST_LOCKED;
                    lock_ch_d    = grant_idx;
                end
            end else if (sel_last) begin
                lock_state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_state_q <= ST_IDLE;
            lock_ch_q    <= '0;
        end else begin
            lock_state_q <= lock_state_d;
            lock_ch_q    <= lock_ch_d;
        end
    end
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_nx1_stream.sv
// Bench for mux_nx1_stream: two instances checked against a beat-level reference model.
//   dut_s : RR_MODE=0, N_CH=5 (sel-driven, out-of-range sel reachable)
//   dut_r : RR_MODE=1, N_CH=4 (round-robin)
module tb_mux_nx1_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic [4:0]  s_valid, s_last, s_ready;
    logic [19:0] s_data;
    logic [2:0]  s_sel, s_oc;
    logic        s_ov, s_ol, s_ordy;
    logic [3:0]  s_od;

    logic [3:0]  r_valid, r_last, r_ready;
    logic [15:0] r_data;
    logic [1:0]  r_sel, r_oc;
    logic        r_ov, r_ol, r_ordy;
    logic [3:0]  r_od;

    mux_nx1_stream #(
        .N_CH   (5),
        .W      (4),
        .RR_MODE(0)
    ) dut_s (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (s_valid),
        .in_data  (s_data),
        .in_last  (s_last),
        .in_ready (s_ready),
        .sel      (s_sel),
        .out_valid(s_ov),
        .out_data (s_od),
        .out_last (s_ol),
        .out_ch   (s_oc),
        .out_ready(s_ordy)
    );

    mux_nx1_stream #(
        .N_CH   (4),
        .W      (4),
        .RR_MODE(1)
    ) dut_r (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (r_valid),
        .in_data  (r_data),
        .in_last  (r_last),
        .in_ready (r_ready),
        .sel      (r_sel),
        .out_valid(r_ov),
        .out_data (r_od),
        .out_last (r_ol),
        .out_ch   (r_oc),
        .out_ready(r_ordy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state, index 0 = dut_s, 1 = dut_r.
    int m_n[2]  = '{5, 4};
    int m_rr[2] = '{0, 1};
    int m_ov[2], m_od[2], m_ol[2], m_oc[2], m_ptr[2], m_lock[2], m_lch[2], m_acc[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ov[d] = 0; m_od[d] = 0; m_ol[d] = 0; m_oc[d] = 0;
            m_ptr[d] = m_n[d] - 1; m_lock[d] = 0; m_lch[d] = 0; m_acc[d] = -1;
        end
    endtask

    function automatic int grant_of(input int d, input logic [15:0] valid, input int sel);
        if (m_lock[d] != 0) return m_lch[d];
        if (m_rr[d] == 0) return (sel < m_n[d]) ? sel : -1;
        for (int i = 1; i <= m_n[d]; i++) begin
            int k;
            k = (m_ptr[d] + i) % m_n[d];
            if (valid[k]) return k;
        end
        return -1;
    endfunction

    function automatic int exp_ready(input int d, input logic [15:0] valid, input int sel,
                                     input bit ordy, input bit in_reset);
        int g;
        if (in_reset) return 0;
        g = grant_of(d, valid, sel);
        if ((m_ov[d] == 0 || ordy) && g >= 0) return 1 << g;
        return 0;
    endfunction

    task automatic model_step(input int d, input logic [15:0] valid, input logic [63:0] data,
                              input logic [15:0] last, input int sel, input bit ordy);
        int g;
        g = grant_of(d, valid, sel);
        m_acc[d] = -1;
        if ((m_ov[d] == 0 || ordy) && g >= 0 && valid[g]) begin
            m_acc[d] = g;
            m_ov[d]  = 1;
            m_od[d]  = int'((data >> (4 * g)) & 64'hF);
            m_ol[d]  = int'(last[g]);
            m_oc[d]  = g;
            if (m_rr[d] != 0) m_ptr[d] = g;
`ifdef MUX_NX1_STREAM_PKT_LOCK_EN
            if (m_lock[d] == 0 && !last[g]) begin
                m_lock[d] = 1;
                m_lch[d]  = g;
            end else if (m_lock[d] != 0 && last[g]) begin
                m_lock[d] = 0;
            end
`endif
        end else if (ordy) begin
            m_ov[d] = 0;
        end
    endtask

    task automatic compare_all();
        bit rst;
        rst = !reset_n;
        chk("s_out_valid", 64'(s_ov), 64'(m_ov[0]));
        chk("s_out_data",  64'(s_od), 64'(m_od[0]));
        chk("s_out_last",  64'(s_ol), 64'(m_ol[0]));
        chk("s_out_ch",    64'(s_oc), 64'(m_oc[0]));
        chk("s_in_ready",  64'(s_ready),
            64'(exp_ready(0, 16'(s_valid), int'(s_sel), s_ordy, rst)));
        chk("r_out_valid", 64'(r_ov), 64'(m_ov[1]));
        chk("r_out_data",  64'(r_od), 64'(m_od[1]));
        chk("r_out_last",  64'(r_ol), 64'(m_ol[1]));
        chk("r_out_ch",    64'(r_oc), 64'(m_oc[1]));
        chk("r_in_ready",  64'(r_ready),
            64'(exp_ready(1, 16'(r_valid), int'(r_sel), r_ordy, rst)));
    endtask

    // Inputs are driven just after a falling edge; this checks, advances the model and
    // returns at the next falling edge with the new registered outputs visible.
    task automatic cycle();
        #1;
        compare_all();
        model_step(0, 16'(s_valid), 64'(s_data), 16'(s_last), int'(s_sel), s_ordy);
        model_step(1, 16'(r_valid), 64'(r_data), 16'(r_last), int'(r_sel), r_ordy);
        @(posedge clk);
        @(negedge clk);
    endtask

    int rr_seq[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
`ifdef MUX_NX1_STREAM_PKT_LOCK_EN
    int lk_seq[4]  = '{1, 1, 1, 2};
`else
    int lk_seq[4]  = '{1, 2, 0, 1};
`endif
    int c1;

    initial begin
        reset_n = 1'b0;
        s_valid = '0; s_last = '1; s_data = '0; s_sel = '0; s_ordy = 1'b1;
        r_valid = '0; r_last = '1; r_data = '0; r_sel = '0; r_ordy = 1'b1;
        model_reset();
        #3;
        compare_all();
        @(negedge clk);
        reset_n = 1'b1;

        // Round-robin: all channels valid, sequence from reset pointer starts at ch0.
        // sel-mode: sel=2 with ch2 data A.
        r_valid = 4'hF;
        s_sel = 3'd2; s_valid = 5'b00100; s_data = 20'h00A00;
        for (int i = 0; i < 8; i++) begin
            r_data = 16'($urandom);
            cycle();
            chk("rr_seq_ch", 64'(r_oc), 64'(rr_seq[i]));
            chk("rr_seq_valid", 64'(r_ov), 64'd1);
            if (i == 0) begin
                chk("sel2_data", 64'(s_od), 64'hA);
                chk("sel2_ch", 64'(s_oc), 64'd2);
                // Out-of-range select with every channel valid.
                s_sel = 3'd7; s_valid = 5'b11111;
                #1 chk("sel7_ready", 64'(s_ready), 64'd0);
            end
            if (i == 1) chk("sel7_no_beat", 64'(s_ov), 64'd0);
        end

        // Back-pressure on dut_s.
        s_sel = 3'd1; s_valid = 5'b00010; s_data = 20'h00050;
        cycle();
        s_ordy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_data = 20'($urandom);
            cycle();
            chk("bp_hold_data", 64'(s_od), 64'h5);
            chk("bp_hold_ch", 64'(s_oc), 64'd1);
        end
        #1 chk("bp_ready_low", 64'(s_ready), 64'd0);
        s_ordy = 1'b1; s_data = 20'h00090;
        cycle();
        chk("bp_reload_data", 64'(s_od), 64'h9);
        chk("bp_reload_valid", 64'(s_ov), 64'd1);

        // Packet lock scenario on dut_r: park pointer at ch0, then ch1 sends 3 beats.
        r_valid = 4'b0001; r_last = 4'hF;
        cycle();
        c1 = 0;
        for (int i = 0; i < 4; i++) begin
            r_valid = 4'b0111;
            r_last  = {1'b1, 1'b1, (c1 == 2), 1'b1};
            r_data  = 16'($urandom);
            cycle();
            chk("lock_seq_ch", 64'(r_oc), 64'(lk_seq[i]));
            if (m_acc[1] == 1) c1++;
        end

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            s_valid = 5'($urandom); s_data = 20'($urandom);
            s_last  = 5'($urandom | $urandom); s_sel = 3'($urandom_range(0, 7));
            s_ordy  = ($urandom_range(0, 3) != 0);
            r_valid = 4'($urandom); r_data = 16'($urandom);
            r_last  = 4'($urandom | $urandom); r_sel = 2'($urandom);
            r_ordy  = ($urandom_range(0, 3) != 0);
            cycle();
        end

        // Reset in the middle of a held beat.
        s_valid = 5'b11111; s_sel = 3'd1; s_ordy = 1'b1; s_last = 5'b00000;
        r_valid = 4'hF; r_ordy = 1'b1; r_last = 4'h0;
        cycle();
        s_ordy = 1'b0; r_ordy = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_s_valid", 64'(s_ov), 64'd0);
        chk("rst_s_ch", 64'(s_oc), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_r_valid", 64'(r_ov), 64'd0);
        chk("rst_r_ch", 64'(r_oc), 64'd0);
        chk("rst_r_ready", 64'(r_ready), 64'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        s_ordy = 1'b1; r_ordy = 1'b1; s_last = 5'b11111; r_last = 4'hF;
        cycle();
        chk("post_rst_r_ch", 64'(r_oc), 64'd0);
        chk("post_rst_r_valid", 64'(r_ov), 64'd1);
        for (int i = 0; i < 4; i++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
